instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Fetch/decode/dispatch controller for the microcontroller core. It owns the program counter and reads 16-bit instructions from synchronous instruction memory. It hands each instruction to exactly one of four execution-unit FSMs (MOV and siblings). While that unit runs, it arbitrates the shared general-register select bus (one-hot `rxOut`/`rxIn`) so only the granted unit drives it.

## Interface
- `PC_W`, default 8: program-counter / instruction-address width.
- `TIMEOUT`, default 15: maximum EXEC cycles allowed before a unit must assert done.
- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `run` in 1: level; 1 = keep fetching, 0 = stop after the current instruction.
- `imem_addr` out PC_W: instruction address; always equals `pc`.
- `imem_data` in 16: instruction word, valid one cycle after `imem_addr`.
- `ir` out 16: instruction presented to all units; opcode field is `ir[15:12]`.
- `unit_go` out 4: one-hot grant; bit k means unit k owns the bus.
- `unit_done` in 4: per-unit done pulse.
- `unit_pcinc` in 4: per-unit PC-increment request.
- `unit_rxout` in 24: unit k's 6-bit read select, at bits `[6k+5:6k]`.
- `unit_rxin` in 24: unit k's 6-bit write select, at bits `[6k+5:6k]`.
- `bus_rxout` out 6: arbitrated register read select.
- `bus_rxin` out 6: arbitrated register write select.
- `busy` out 1: 1 in FETCH, DECODE, EXEC and RETIRE.
- `halted` out 1: sticky; set by HALT.
- `fault` out 1: sticky error flag.
- `fault_code` out 2: 01 = illegal opcode, 10 = unit timeout.

## Operation
- Opcode map for `ir[15:12]`:
  - 0000: NOP.
  - 1111: HALT.
  - 0100–0111: unit k = opcode − 4 (unit 1 = MOV, opcode 0101).
  - All other opcodes are illegal.
- States:
  - IDLE: `ir`=0. Goes to FETCH when `run`=1.
  - FETCH: `imem_addr`=`pc`. Goes to DECODE.
  - DECODE: latches `imem_data` into `ir_q`; `ir` is still 0. Next state by opcode:
    - NOP: `pc`+1, then RETIRE.
    - HALT: HALTED; `pc` unchanged.
    - Illegal: FAULT with code 01.
    - Unit opcode: EXEC, with grant k recorded.
  - EXEC:
    - Drives `ir`=`ir_q` and `unit_go`=one-hot(k).
    - Drives `bus_rxout`/`bus_rxin` from unit k's slices.
    - Every cycle with `unit_pcinc[k]`=1 increments `pc`.
    - `unit_done[k]`=1 goes to RETIRE.
    - Cycle counter reaching `TIMEOUT` with no done goes to FAULT with code 10.
  - RETIRE: `ir`=0, `unit_go`=0, bus=0, held for exactly one cycle so units return to their idle state. Then FETCH if `run`=1, else IDLE.
  - HALTED and FAULT: terminal. `ir`=0, `unit_go`=0, bus=0, `busy`=0. Only `rst` exits.
- Arbitration:
  - Inputs from non-granted units (`done`, `pcinc`, `rxout`, `rxin`) are ignored.
  - Outside EXEC, `bus_rxout`=`bus_rxin`=0 regardless of the inputs.
- Arithmetic:
  - `pc` is PC_W bits and wraps from 2^PC_W−1 to 0.
  - The EXEC cycle counter clears on entry to EXEC.
- `run` falling mid-instruction: the current instruction completes; the sequencer stops at RETIRE → IDLE.
- When `unit_done[k]` and `unit_pcinc[k]` are asserted in the same cycle, the increment is applied before RETIRE.

## Timing
- Reset values (asynchronous):
  - State IDLE.
  - `pc`=0, `imem_addr`=0.
  - `ir`=0, `unit_go`=0.
  - `bus_rxout`=0, `bus_rxin`=0.
  - `busy`=0, `halted`=0, `fault`=0, `fault_code`=00.
- Reset asserted mid-EXEC forces the reset values immediately, with no RETIRE cycle.
- `ir`, `unit_go`, `pc`, `halted`, `fault` and `fault_code` are registered. `bus_*` is combinational from the granted slice and the state.
- Per-instruction cycle counts:
  - Unit instruction: 1 FETCH + 1 DECODE + n EXEC + 1 RETIRE, where n = cycles to done (minimum 1).
  - NOP: 3 cycles.
  - HALT: 2 cycles, then HALTED.
- A unit sees `ir` and `unit_go` on the first EXEC cycle and may respond no earlier than the following edge.
- Timeout: FAULT is entered on the edge after the TIMEOUT-th EXEC cycle without done.

## Test plan
- Reset, then `run`=1 with `imem[0]`=NOP and `imem[1]`=HALT:
  - FETCH → DECODE → RETIRE → FETCH → DECODE → HALTED.
  - `pc`=1, `halted`=1, `busy`=0.
- `imem[0]`=0x5045 (MOV), model unit 1 pulses pcinc in EXEC cycle 2, drives `rxout`=000001 / `rxin`=000010 in cycle 3, and asserts done in cycle 4:
  - `unit_go`=0010 throughout EXEC.
  - `bus_rxout`/`bus_rxin` follow unit 1.
  - `pc`=1.
  - `ir`=0 in RETIRE.
- With unit 1 granted, unit 2 drives `rxin`=111111 and done=1:
  - Bus shows only unit 1's values.
  - No early RETIRE.
- Illegal opcode 0x2000:
  - DECODE → FAULT, `fault`=1, `fault_code`=01, `pc`=0.
  - State holds until `rst`.
- Unit opcode with no done:
  - FAULT with code 10 after exactly 15 EXEC cycles.
- `pc`=2^PC_W−1 executing NOP:
  - `pc` wraps to 0.
- Separately, `run` dropped during EXEC:
  - The instruction completes, then RETIRE → IDLE.
- Separately, `rst` asserted during EXEC:
  - All outputs return to their reset values.

Source files
------------

// File: rtl/instr_sequencer_if.sv
// Sequencer-facing bundle: instruction memory port, the four execution-unit
// handshakes and the arbitrated general-register select bus.
interface instr_sequencer_if #(
    parameter int PC_W = 8
);
    logic            run;
    logic [PC_W-1:0] imem_addr;
    logic [15:0]     imem_data;
    logic [15:0]     ir;
    logic [3:0]      unit_go;
    logic [3:0]      unit_done;
    logic [3:0]      unit_pcinc;
    logic [23:0]     unit_rxout;
    logic [23:0]     unit_rxin;
    logic [5:0]      bus_rxout;
    logic [5:0]      bus_rxin;
    logic            busy;
    logic            halted;
    logic            fault;
    logic [1:0]      fault_code;

    // Sequencer side
    modport master (
        input  run, imem_data, unit_done, unit_pcinc, unit_rxout, unit_rxin,
        output imem_addr, ir, unit_go, bus_rxout, bus_rxin,
        output busy, halted, fault, fault_code
    );

    // Memory / execution-unit side
    modport slave (
        output run, imem_data, unit_done, unit_pcinc, unit_rxout, unit_rxin,
        input  imem_addr, ir, unit_go, bus_rxout, bus_rxin,
        input  busy, halted, fault, fault_code
    );
endinterface

// File: rtl/instr_sequencer.sv
// Fetch/decode/dispatch controller: owns the PC, fetches 16-bit words from
// synchronous memory, grants one of four execution units per instruction and
// muxes that unit's register selects onto the shared bus.
module instr_sequencer #(
    parameter int PC_W    = 8,
    parameter int TIMEOUT = 15
) (
    input logic               clk,
    input logic               rst,
    instr_sequencer_if.master sif
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_RETIRE, S_HALTED, S_FAULT
    } state_t;

    state_t          state, state_n;
    logic [PC_W-1:0] pc;
    logic [15:0]     ir_q;
    logic [1:0]      gnt;
    logic [CNT_W-1:0] cnt;

    // Decode of the word arriving from memory during DECODE
    logic [3:0] op;
    logic       op_nop, op_halt, op_unit;
    assign op      = sif.imem_data[15:12];
    assign op_nop  = (op == 4'h0);
    assign op_halt = (op == 4'hF);
    assign op_unit = (op[3:2] == 2'b01);

    // Only the granted unit's handshake is ever looked at
    logic       g_done, g_pcinc, tmo;
    logic [4:0] base;
    assign g_done  = sif.unit_done[gnt];
    assign g_pcinc = sif.unit_pcinc[gnt];
    assign tmo     = (cnt == CNT_W'(TIMEOUT - 1));
    assign base    = 5'(gnt) * 5'd6;

    assign sif.imem_addr = pc;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   if (sif.run) state_n = S_FETCH;
            S_FETCH:  state_n = S_DECODE;
            S_DECODE: begin
                if (op_nop)       state_n = S_RETIRE;
                else if (op_halt) state_n = S_HALTED;
                else if (op_unit) state_n = S_EXEC;
                else              state_n = S_FAULT;
            end
            S_EXEC: begin
                if (g_done)   state_n = S_RETIRE;
                else if (tmo) state_n = S_FAULT;
            end
            S_RETIRE: state_n = sif.run ? S_FETCH : S_IDLE;
            default:  state_n = state;
        endcase
    end

    // Combinational outputs: busy flag and the arbitrated select bus
    always_comb begin
        sif.busy      = (state == S_FETCH) || (state == S_DECODE) ||
                        (state == S_EXEC)  || (state == S_RETIRE);
        sif.bus_rxout = 6'd0;
        sif.bus_rxin  = 6'd0;
        if (state == S_EXEC) begin
            sif.bus_rxout = sif.unit_rxout[base +: 6];
            sif.bus_rxin  = sif.unit_rxin[base +: 6];
        end
    end

    // Registered datapath: PC, instruction latch, grant, EXEC watchdog, flags.
    // ir/unit_go are loaded from next state so they are valid on the very
    // first EXEC cycle and drop to zero on the first cycle after it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc             <= '0;
            ir_q           <= '0;
            gnt            <= '0;
            cnt            <= '0;
            sif.ir         <= '0;
            sif.unit_go    <= '0;
            sif.halted     <= 1'b0;
            sif.fault      <= 1'b0;
            sif.fault_code <= 2'b00;
        end else begin
            if (state == S_DECODE) begin
                ir_q <= sif.imem_data;
                gnt  <= op[1:0];
                cnt  <= '0;
                if (op_nop)  pc <= pc + 1'b1;
                if (op_halt) sif.halted <= 1'b1;
                if (!op_nop && !op_halt && !op_unit) begin
                    sif.fault      <= 1'b1;
                    sif.fault_code <= 2'b01;
                end
            end
            if (state == S_EXEC) begin
                cnt <= cnt + 1'b1;
                if (g_pcinc) pc <= pc + 1'b1;
                if (!g_done && tmo) begin
                    sif.fault      <= 1'b1;
                    sif.fault_code <= 2'b10;
                end
            end
            if (state_n == S_EXEC) begin
                sif.ir      <= (state == S_DECODE) ? sif.imem_data : ir_q;
                sif.unit_go <= 4'b0001 << ((state == S_DECODE) ? op[1:0] : gnt);
            end else begin
                sif.ir      <= '0;
                sif.unit_go <= '0;
            end
        end
    end
endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: bench-owned synchronous memory, a unit responder
// that plays each queued unit execution, and an instruction-level model that
// predicts busy-cycle totals, final PC and terminal flags for random programs.
module tb_instr_sequencer;
    localparam int PC_W    = 8;
    localparam int TIMEOUT = 15;

    logic clk, rst;
    instr_sequencer_if #(.PC_W(PC_W)) bus_if ();

    instr_sequencer #(.PC_W(PC_W), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .sif (bus_if.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Synchronous instruction memory
    logic [15:0] mem [256];
    always @(posedge clk) bus_if.imem_data <= mem[bus_if.imem_addr];

    // One entry per unit execution, in program order
    typedef struct {
        logic [15:0] ir;
        int          k;
        int          n;     // EXEC cycle carrying done; 0 = never
        logic [15:0] mask;  // bit e = pcinc in EXEC cycle e
    } ex_t;
    ex_t exq[$];
    ex_t cur = '{16'h0, 0, 0, 16'h0};
    int  e = 0;
    logic [3:0]  rd, rp;
    logic [23:0] ro, ri;
    logic [5:0]  xo, xi;

    // Unit responder: random noise on every unit, the scripted response on the
    // granted one, non-granted units always claiming done
    always @(negedge clk) begin
        if (rst) begin
            e = 0;
            bus_if.unit_done  = '0;
            bus_if.unit_pcinc = '0;
            bus_if.unit_rxout = '0;
            bus_if.unit_rxin  = '0;
        end else begin
            ro = $urandom; ri = $urandom; rd = 4'($urandom); rp = 4'($urandom);
            if (bus_if.unit_go != 4'd0) begin
                e++;
                if (e == 1) begin
                    if (exq.size() == 0) chk("exq_empty", 1, 0);
                    else cur = exq.pop_front();
                end
                chk("unit_go", bus_if.unit_go, 4'b0001 << cur.k);
                chk("ir_exec", bus_if.ir, cur.ir);
                rd = 4'hF;
                rd[cur.k] = (e == cur.n);
                rp[cur.k] = (e < 16) ? cur.mask[e] : 1'b0;
                xo = ro[6*cur.k +: 6];
                xi = ri[6*cur.k +: 6];
            end else begin
                e = 0;
                chk("ir_idle", bus_if.ir, 16'h0);
                xo = 6'd0;
                xi = 6'd0;
            end
            bus_if.unit_done  = rd;
            bus_if.unit_pcinc = rp;
            bus_if.unit_rxout = ro;
            bus_if.unit_rxin  = ri;
            #1;
            chk("bus_rxout", bus_if.bus_rxout, xo);
            chk("bus_rxin", bus_if.bus_rxin, xi);
        end
    end

    task automatic chk_rst_vals(input string tag);
        chk({tag, "_addr"}, bus_if.imem_addr, 0);
        chk({tag, "_ir"}, bus_if.ir, 0);
        chk({tag, "_go"}, bus_if.unit_go, 0);
        chk({tag, "_bus"}, {bus_if.bus_rxout, bus_if.bus_rxin}, 0);
        chk({tag, "_flags"}, {bus_if.busy, bus_if.halted, bus_if.fault, bus_if.fault_code}, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus_if.run = 1'b0;
        exq.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Raise run and count busy cycles until the sequencer goes non-busy
    task automatic run_prog(input bit drop, output int bcnt);
        bit seen = 0, fin = 0;
        bcnt = 0;
        @(negedge clk);
        bus_if.run = 1'b1;
        for (int c = 0; c < 5000 && !fin; c++) begin
            @(negedge clk);
            if (drop && bus_if.unit_go != 4'd0) bus_if.run = 1'b0;
            if (bus_if.busy) begin bcnt++; seen = 1; end
            else if (seen) fin = 1;
        end
        if (!fin) chk("run_bound", 0, 1);
    endtask

    // Random program built while walking it; returns the predicted outcome
    task automatic gen_trial(output int xb, output logic [7:0] xpc,
                             output logic xh, output logic xf, output logic [1:0] xc);
        logic [7:0]  pc = 0;
        logic [15:0] ins, m;
        bit          stop = 0;
        int          r, k, n, pick;
        xb = 0; xh = 0; xf = 0; xc = 0;
        for (int i = 0; i < 24 && !stop; i++) begin
            r = $urandom_range(99);
            if (i == 23 || r >= 95) begin
                mem[pc] = {4'hF, 12'($urandom)};
                xb += 2; xh = 1; stop = 1;
            end else if (r < 15) begin
                mem[pc] = {4'h0, 12'($urandom)};
                xb += 3; pc++;
            end else if (r < 88) begin
                k = $urandom_range(3);
                ins = {4'(4 + k), 12'($urandom)};
                mem[pc] = ins;
                if ($urandom_range(19) == 0) begin
                    m = 16'($urandom) & 16'hFFFE;
                    exq.push_back('{ins, k, 0, m});
                    xb += 2 + TIMEOUT; pc += 8'($countones(m));
                    xf = 1; xc = 2'b10; stop = 1;
                end else begin
                    n = $urandom_range(1, 6);
                    m = 16'($urandom) & 16'(((1 << (n + 1)) - 2));
                    if (m == 0) m[n] = 1'b1;
                    exq.push_back('{ins, k, n, m});
                    xb += 3 + n; pc += 8'($countones(m));
                end
            end else begin
                pick = $urandom_range(9);
                mem[pc] = {4'((pick < 3) ? pick + 1 : pick + 5), 12'($urandom)};
                xb += 2; xf = 1; xc = 2'b01; stop = 1;
            end
        end
        xpc = pc;
    endtask

    initial begin
        int bc, xb;
        logic [7:0] xpc;
        logic xh, xf;
        logic [1:0] xc;
        bit ok;

        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        rst = 1'b1;
        bus_if.run = 1'b0;
        #1;
        chk_rst_vals("reset");
        do_reset();

        // NOP then HALT
        mem[0] = 16'h0000; mem[1] = 16'hF000;
        run_prog(0, bc);
        chk("nop_halt_busy", bc, 5);
        chk("nop_halt_pc", bus_if.imem_addr, 1);
        chk("nop_halt_flags", {bus_if.busy, bus_if.halted, bus_if.fault}, 3'b010);

        // MOV with pcinc in cycle 2, done in cycle 4, then HALT
        do_reset();
        mem[0] = 16'h5045; mem[1] = 16'hF000;
        exq.push_back('{16'h5045, 1, 4, 16'h0004});
        run_prog(0, bc);
        chk("mov_busy", bc, 9);
        chk("mov_pc", bus_if.imem_addr, 1);
        chk("mov_halted", bus_if.halted, 1);
        chk("mov_exq", exq.size(), 0);

        // Illegal opcode
        do_reset();
        mem[0] = 16'h2000;
        run_prog(0, bc);
        chk("ill_busy", bc, 2);
        repeat (3) @(negedge clk);
        chk("ill_flags", {bus_if.busy, bus_if.halted, bus_if.fault, bus_if.fault_code}, 5'b00101);
        chk("ill_pc", bus_if.imem_addr, 0);

        // Unit that never finishes
        do_reset();
        mem[0] = 16'h6000;
        exq.push_back('{16'h6000, 2, 0, 16'h0});
        run_prog(0, bc);
        chk("tmo_busy", bc, 2 + TIMEOUT);
        chk("tmo_code", {bus_if.fault, bus_if.fault_code}, 3'b110);
        chk("tmo_pc", bus_if.imem_addr, 0);

        // run dropped during EXEC
        do_reset();
        mem[0] = 16'h5045; mem[1] = 16'h4000;
        exq.push_back('{16'h5045, 1, 4, 16'h0004});
        run_prog(1, bc);
        chk("drop_busy", bc, 7);
        repeat (3) @(negedge clk);
        chk("drop_idle", {bus_if.busy, bus_if.halted, bus_if.fault}, 3'b000);
        chk("drop_pc", bus_if.imem_addr, 1);
        chk("drop_exq", exq.size(), 0);

        // Reset asserted mid-EXEC
        do_reset();
        mem[0] = 16'h7123;
        exq.push_back('{16'h7123, 3, 0, 16'h0});
        @(negedge clk);
        bus_if.run = 1'b1;
        ok = 0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            if (bus_if.unit_go != 4'd0) ok = 1;
        end
        chk("mid_exec_seen", ok, 1);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_rst_vals("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        bus_if.run = 1'b0;

        // PC wrap: 256 NOPs, HALT planted at 0 once the PC reaches the top
        do_reset();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        fork
            begin
                for (int c = 0; c < 2000; c++) begin
                    @(negedge clk);
                    if (bus_if.imem_addr == 8'hFF) begin
                        mem[0] = 16'hF000;
                        break;
                    end
                end
            end
            run_prog(0, bc);
        join
        chk("wrap_busy", bc, 256 * 3 + 2);
        chk("wrap_pc", bus_if.imem_addr, 0);
        chk("wrap_halted", bus_if.halted, 1);

        // Random programs against the instruction-level model
        for (int t = 0; t < 30; t++) begin
            do_reset();
            gen_trial(xb, xpc, xh, xf, xc);
            run_prog(0, bc);
            chk("rnd_busy", bc, xb);
            chk("rnd_pc", bus_if.imem_addr, xpc);
            chk("rnd_term", {bus_if.halted, bus_if.fault, bus_if.fault_code}, {xh, xf, xc});
            chk("rnd_exq", exq.size(), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
